hazard_controller: RTL

Pipeline sequencing controller for the 5-stage RV32I core. It decides each cycle which pipeline registers advance, hold or flush. It covers the hazards operand forwarding cannot resolve: load-use in ID, taken branch/jump resolved in EX, and a data memory that is not ready in MEM. A watchdog on memory waits drives the core into a frozen error state.

---
 rtl/hazard_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stall, branch flush, memory-wait freeze and watchdog.
// Optional stall_cycles counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT       = 16,
  parameter int unsigned STALL_COUNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ID_instruction,
  input  logic [31:0] EX_instruction,
  input  logic        EX_reg_write_enable,
  input  logic        EX_mem_to_reg,
  input  logic        EX_branch_taken,
  input  logic        MEM_mem_request,
  input  logic        MEM_mem_ready,
  output logic        PC_write_enable,
  output logic        IF_ID_write_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_write_enable,
  output logic        ID_EX_flush,
  output logic        EX_MEM_write_enable,
  output logic        MEM_WB_flush,
  output logic        mem_error
`ifdef HAZARD_STALL_COUNTER_EN
  ,
  output logic [STALL_COUNT_WIDTH-1:0] stall_cycles
`endif
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_count;
  logic [WAIT_W-1:0] w_next_wait_count;

  logic [6:0] w_id_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_ex_rd;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_load_use;
  logic       w_mem_wait;
  logic       w_wait_last;

  assign w_id_opcode = ID_instruction[6:0];
  assign w_rs1       = ID_instruction[19:15];
  assign w_rs2       = ID_instruction[24:20];
  assign w_ex_rd     = EX_instruction[11:7];

  assign w_rs1_used = !((w_id_opcode == OP_LUI) || (w_id_opcode == OP_AUIPC) ||
                        (w_id_opcode == OP_JAL));
  assign w_rs2_used = (w_id_opcode == OP_R) || (w_id_opcode == OP_S) || (w_id_opcode == OP_B);

  assign w_load_use = EX_reg_write_enable && EX_mem_to_reg && (w_ex_rd != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == w_ex_rd)) || (w_rs2_used && (w_rs2 == w_ex_rd)));

  assign w_mem_wait  = MEM_mem_request && !MEM_mem_ready;
  assign w_wait_last = (r_wait_count == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_wait_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_wait_count <= w_next_wait_count;
    end
  end

  // The first wait cycle is seen in RUN (count 0), so each wait cycle bumps the
  // count and the timeout edge ends exactly wait cycle MEM_TIMEOUT.
  always_comb begin
    w_next_state      = r_state;
    w_next_wait_count = r_wait_count;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_wait) begin
          if (w_wait_last) begin
            w_next_state      = ST_ERROR;
            w_next_wait_count = '0;
          end else begin
            w_next_state      = ST_MEM_WAIT;
            w_next_wait_count = r_wait_count + WAIT_W'(1);
          end
        end else begin
          w_next_state      = ST_RUN;
          w_next_wait_count = '0;
        end
      end
      ST_ERROR: begin
        w_next_state      = ST_ERROR;
        w_next_wait_count = '0;
      end
      default: begin
        w_next_state      = ST_RUN;
        w_next_wait_count = '0;
      end
    endcase
  end

  // Pipeline control, highest priority first.
  always_comb begin
    PC_write_enable     = 1'b1;
    IF_ID_write_enable  = 1'b1;
    IF_ID_flush         = 1'b0;
    ID_EX_write_enable  = 1'b1;
    ID_EX_flush         = 1'b0;
    EX_MEM_write_enable = 1'b1;
    MEM_WB_flush        = 1'b0;
    mem_error           = 1'b0;
    if (reset) begin
      PC_write_enable     = 1'b0;
      IF_ID_write_enable  = 1'b0;
      IF_ID_flush         = 1'b1;
      ID_EX_write_enable  = 1'b0;
      ID_EX_flush         = 1'b1;
      EX_MEM_write_enable = 1'b0;
      MEM_WB_flush        = 1'b1;
    end else if ((r_state == ST_ERROR) || w_mem_wait) begin
      PC_write_enable     = 1'b0;
      IF_ID_write_enable  = 1'b0;
      ID_EX_write_enable  = 1'b0;
      EX_MEM_write_enable = 1'b0;
      MEM_WB_flush        = 1'b1;
      mem_error           = (r_state == ST_ERROR);
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (w_load_use) begin
      PC_write_enable    = 1'b0;
      IF_ID_write_enable = 1'b0;
      ID_EX_flush        = 1'b1;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [STALL_COUNT_WIDTH-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (!PC_write_enable && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + STALL_COUNT_WIDTH'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

  logic w_unused;
  assign w_unused = &{1'b0, ID_instruction[31:25], ID_instruction[14:12],
                      EX_instruction[31:12], EX_instruction[6:0]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, ID_instruction[31:25], ID_instruction[14:12],
                      EX_instruction[31:12], EX_instruction[6:0], 1'(STALL_COUNT_WIDTH)};
`endif

endmodule
